dpram_be_pipe: RTL and testbench
================================

// Module: dpram_be_pipe
// PURPOSE
// - Parametrised true dual-port RAM, successor to the basic dual-port RAM: byte-write enables,
//   valid/ready request handshake per port, 1- or 2-cycle read latency with rvalid tagging.
// - Adds a hardware clear engine (runs after reset and on request), deterministic same-address
//   write-collision resolution and a selectable cross-port read-during-write result.
// - Scratchpad / mailbox storage between two independent masters on one clock.
// PARAMETERS
// - DATA_WIDTH  32  word width; multiple of 8; BE_W = DATA_WIDTH/8
// - ADDR_WIDTH  4   address bits; DEPTH = 2**ADDR_WIDTH words
// - RD_LAT      1   read latency in cycles; legal values 1 and 2
// - RDW_MODE    0   cross-port same-address read during write: 0 = old data, 1 = new (merged) data
// PORTS (x = a, b; one identical set per port)
// - clk           in   1           single clock, rising edge
// - rst_n         in   1           asynchronous, active-low reset
// - clr           in   1           pulse: start a clear of all words to zero
// - init_done     out  1           1 = clear complete, RAM accepting requests
// - req_valid_x   in   1           request valid
// - req_ready_x   out  1           request ready; equals init_done
// - we_x          in   1           1 = write, 0 = read
// - be_x          in   BE_W        byte-write enables; ignored for reads
// - addr_x        in   ADDR_WIDTH  word address
// - wdata_x       in   DATA_WIDTH  write data
// - rvalid_x      out  1           read data valid, one pulse per accepted read
// - rdata_x       out  DATA_WIDTH  read data; held between rvalid pulses
// - coll          out  1           1-cycle pulse: A and B wrote the same address in one cycle
// BEHAVIOUR
// - Reset (rst_n low, async): init_done=0, req_ready_x=0, rvalid_x=0, rdata_x=0, coll=0,
//   read pipelines flushed, clear counter=0, FSM -> CLEAR. RAM contents are not reset;
//   the CLEAR state zeroes them.
// - FSM: CLEAR -> RUN when the counter writes word DEPTH-1 (DEPTH cycles after rst_n rises);
//   RUN -> CLEAR on the edge where clr=1. clr during CLEAR restarts the counter at 0.
// - CLEAR: one word zeroed per cycle at the counter address; req_ready_x=0; requests ignored.
// - init_done rises on the cycle after the last clear write; req_ready_x = init_done.
// - Accept: valid && ready at a rising edge. Writes update enabled bytes only; no rvalid.
// - Read accepted at edge N: rdata_x/rvalid_x presented after edge N+RD_LAT-1 (RD_LAT=1: the
//   edge-N register). Back-to-back reads: one result per cycle, in order, no bubbles.
// - RD_LAT=2 adds one output register stage; rvalid tracks the data through the same stages.
// - Reads in flight when clr is seen still complete with their captured data.
// - Same-address writes, both ports, same cycle: per byte, A wins where be_a=1, B's byte is
//   written where only be_b=1; coll pulses on the next cycle. Different addresses: coll=0.
// - Cross-port read vs write, same address, same cycle: RDW_MODE=0 returns pre-write word;
//   RDW_MODE=1 returns write data merged by be (and by the A-wins rule if both wrote).
// - Read and write on different addresses never interact; address wrap is natural modulo DEPTH.
// - rst_n asserted mid-operation: outputs drop immediately; in-flight reads are lost.
// STRUCTURE
// - Package dpram_pkg: FSM state enum {CLEAR, RUN}, RDW_OLD/RDW_NEW constants, helper
//   function be_merge(old, new, be) for byte-lane merging.
// - Sub-module dpram_rd_pipe (RD_LAT stages of data+valid), one instance per port.
// - Top: storage array, clear counter/FSM, collision compare, write-merge logic.
// TESTING
// - Reset release: ready=0 for 16 cycles, then init_done=1; read every address -> rdata=0.
// - Write A addr 3 data 0xDEADBEEF be=4'hF; read B addr 3 -> rvalid_b after RD_LAT, 0xDEADBEEF.
// - Partial write A addr 5 be=4'b0011 data 0x11112222 over 0xAAAAAAAA -> read 0xAAAA2222.
// - A writes 0x11111111 be=4'hC, B writes 0x22222222 be=4'hF to addr 7 same cycle -> coll pulse,
//   read 0x11112222.
// - Old word 0x0, A reads addr 9 while B writes 0x55 be=4'h1 -> RDW_MODE=0: 0x0; RDW_MODE=1: 0x55.
// - Stream 4 reads then clr mid-stream -> 4 rvalid in order, ready low 16 cycles, words read 0.

Source files
------------

// File: rtl/dpram_pkg.sv
// dpram_pkg: shared types, constants and the byte-lane merge helper for the
// dpram_be_pipe dual-port RAM.
//   state_t   - clear-engine FSM state
//   RDW_OLD / RDW_NEW - cross-port read-during-write result selection
//   be_merge  - byte-lane merge of write data into an old word; sized for the
//               widest supported word, callers cast to their own width
package dpram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  localparam int MAX_DW = 256;
  localparam int MAX_BE = MAX_DW / 8;

  function automatic logic [MAX_DW-1:0] be_merge(input logic [MAX_DW-1:0] old_word,
                                                 input logic [MAX_DW-1:0] new_word,
                                                 input logic [MAX_BE-1:0] be);
    logic [MAX_DW-1:0] res;
    res = old_word;
    for (int i = 0; i < MAX_BE; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dpram_rd_pipe.sv
// dpram_rd_pipe: read-return pipeline, RD_LAT register stages of data + valid.
// Data in each stage only loads when its valid is set, so the output word is
// held between valid pulses.
//   clk, rst_n           clock, async active-low reset (flushes all stages)
//   in_valid, in_data    read accepted this cycle and its selected word
//   out_valid, out_data  delayed copy after RD_LAT edges
module dpram_rd_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [RD_LAT-1:0]     vld;
  logic [DATA_WIDTH-1:0] dat [RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < RD_LAT; i++) dat[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      if (in_valid) dat[0] <= in_data;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) dat[i] <= dat[i-1];
      end
    end
  end

  assign out_valid = vld[RD_LAT-1];
  assign out_data  = dat[RD_LAT-1];

endmodule

// File: rtl/dpram_be_pipe.sv
// dpram_be_pipe: true dual-port RAM with byte enables, valid/ready request
// handshake per port, 1/2-cycle read latency and a hardware clear engine.
//   clk, rst_n        single clock, async active-low reset
//   clr               pulse: zero every word (requests blocked meanwhile)
//   init_done         clear finished, ports accepting requests
//   req_*_a / req_*_b per-port request (valid, ready, we, be, addr, wdata)
//   rvalid_x, rdata_x per-port read return, rdata held between pulses
//   coll              one-cycle pulse after both ports wrote the same word
//
// FSM states
//   state    | meaning
//   ST_CLEAR | zeroing word clr_cnt each cycle, requests refused
//   ST_RUN   | normal operation, both ports ready
module dpram_be_pipe
  import dpram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_LAT     = 1,
  parameter int RDW_MODE   = RDW_OLD
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  output logic                       init_done,
  input  logic                       req_valid_a,
  output logic                       req_ready_a,
  input  logic                       we_a,
  input  logic [DATA_WIDTH/8-1:0]    be_a,
  input  logic [ADDR_WIDTH-1:0]      addr_a,
  input  logic [DATA_WIDTH-1:0]      wdata_a,
  output logic                       rvalid_a,
  output logic [DATA_WIDTH-1:0]      rdata_a,
  input  logic                       req_valid_b,
  output logic                       req_ready_b,
  input  logic                       we_b,
  input  logic [DATA_WIDTH/8-1:0]    be_b,
  input  logic [ADDR_WIDTH-1:0]      addr_b,
  input  logic [DATA_WIDTH-1:0]      wdata_b,
  output logic                       rvalid_b,
  output logic [DATA_WIDTH-1:0]      rdata_b,
  output logic                       coll
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (DATA_WIDTH % 8 != 0 || DATA_WIDTH > MAX_DW) begin : g_bad_width
    $error("dpram_be_pipe: DATA_WIDTH must be a multiple of 8 and at most MAX_DW");
  end
  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
    $error("dpram_be_pipe: RD_LAT must be 1 or 2");
  end

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt, clr_cnt_nxt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // clear engine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      ST_CLEAR: begin
        if (clr) begin
          clr_cnt_nxt = '0;
        end else if (&clr_cnt) begin
          state_nxt   = ST_RUN;
          clr_cnt_nxt = '0;
        end else begin
          clr_cnt_nxt = clr_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (clr) begin
          state_nxt   = ST_CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt   = ST_CLEAR;
        clr_cnt_nxt = '0;
      end
    endcase
  end

  assign init_done   = (state == ST_RUN);
  assign req_ready_a = init_done;
  assign req_ready_b = init_done;

  // request decode and write merge
  logic                  wr_a, wr_b, rd_a, rd_b, same_addr;
  logic [DATA_WIDTH-1:0] old_a, old_b, merged_a, merged_b, merged_both;
  logic [DATA_WIDTH-1:0] rd_word_a, rd_word_b;

  assign wr_a      = req_valid_a & init_done & we_a;
  assign wr_b      = req_valid_b & init_done & we_b;
  assign rd_a      = req_valid_a & init_done & ~we_a;
  assign rd_b      = req_valid_b & init_done & ~we_b;
  assign same_addr = (addr_a == addr_b);

  assign old_a = mem[addr_a];
  assign old_b = mem[addr_b];

  assign merged_a = DATA_WIDTH'(be_merge(MAX_DW'(old_a), MAX_DW'(wdata_a), MAX_BE'(be_a)));
  assign merged_b = DATA_WIDTH'(be_merge(MAX_DW'(old_b), MAX_DW'(wdata_b), MAX_BE'(be_b)));
  // Same-address double write: B's bytes first, then A's bytes on top.
  assign merged_both = DATA_WIDTH'(be_merge(MAX_DW'(merged_b), MAX_DW'(wdata_a),
                                            MAX_BE'(be_a)));

  // A reading port never writes in the same cycle, so only the other port can
  // alter the word it sees.
  assign rd_word_a = (RDW_MODE == RDW_NEW && wr_b && same_addr) ? merged_b : old_a;
  assign rd_word_b = (RDW_MODE == RDW_NEW && wr_a && same_addr) ? merged_a : old_b;

  // storage, deliberately not reset; the clear engine zeroes it
  always_ff @(posedge clk) begin
    if (!init_done) begin
      mem[clr_cnt] <= '0;
    end else begin
      if (wr_a) mem[addr_a] <= (wr_b && same_addr) ? merged_both : merged_a;
      if (wr_b && !(wr_a && same_addr)) mem[addr_b] <= merged_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) coll <= 1'b0;
    else        coll <= wr_a & wr_b & same_addr;
  end

  dpram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .RD_LAT(RD_LAT)) u_rd_pipe_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (rd_a),
    .in_data  (rd_word_a),
    .out_valid(rvalid_a),
    .out_data (rdata_a)
  );

  dpram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .RD_LAT(RD_LAT)) u_rd_pipe_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (rd_b),
    .in_data  (rd_word_b),
    .out_valid(rvalid_b),
    .out_data (rdata_b)
  );

endmodule

// File: tb/tb_dpram_be_pipe.sv
// tb_dpram_be_pipe: scoreboard bench for dpram_be_pipe. A word-array reference
// model predicts read results at issue time; a negedge monitor pops and
// compares whenever rvalid is presented.
module tb_dpram_be_pipe;

  parameter int RD_LAT   = 1;
  parameter int RDW_MODE = 0;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int BW    = DW / 8;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr;
  logic          init_done;
  logic          req_valid_a, req_ready_a, we_a, rvalid_a;
  logic [BW-1:0] be_a;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] wdata_a, rdata_a;
  logic          req_valid_b, req_ready_b, we_b, rvalid_b;
  logic [BW-1:0] be_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] wdata_b, rdata_b;
  logic          coll;

  dpram_be_pipe #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LAT(RD_LAT), .RDW_MODE(RDW_MODE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .init_done(init_done),
    .req_valid_a(req_valid_a), .req_ready_a(req_ready_a), .we_a(we_a), .be_a(be_a),
    .addr_a(addr_a), .wdata_a(wdata_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_valid_b(req_valid_b), .req_ready_b(req_ready_b), .we_b(we_b), .be_b(be_b),
    .addr_b(addr_b), .wdata_b(wdata_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .coll(coll)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          valid;
    logic          we;
    logic [BW-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          qa[$];
  exp_t          qb[$];
  logic [DW-1:0] ref_mem [DEPTH];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            clr_left = 0;
  logic          exp_coll = 1'b0;
  logic [DW-1:0] last_a = '0;
  logic [DW-1:0] last_b = '0;

  always @(posedge clk) cyc++;

  function automatic req_t idle();
    return '0;
  endfunction

  function automatic req_t rd(input logic [AW-1:0] a);
    req_t r;
    r = '0; r.valid = 1'b1; r.addr = a;
    return r;
  endfunction

  function automatic req_t wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [BW-1:0] be);
    req_t r;
    r.valid = 1'b1; r.we = 1'b1; r.be = be; r.addr = a; r.wdata = d;
    return r;
  endfunction

  function automatic req_t rnd_req();
    req_t r;
    r.valid = ($urandom_range(0, 3) != 0);
    r.we    = ($urandom_range(0, 1) == 1);
    r.be    = BW'($urandom);
    r.addr  = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
    r.wdata = $urandom;
    return r;
  endfunction

  // each enabled byte lane takes the new byte, others keep the old one
  function automatic logic [DW-1:0] ref_merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                              input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = o;
    for (int i = 0; i < BW; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  task automatic drive_idle();
    clr = 1'b0;
    req_valid_a = 1'b0; we_a = 1'b0; be_a = '0; addr_a = '0; wdata_a = '0;
    req_valid_b = 1'b0; we_b = 1'b0; be_b = '0; addr_b = '0; wdata_b = '0;
  endtask

  // One clock: drive requests, update the model, advance to the next negedge.
  task automatic cycle(input req_t ra, input req_t rb, input logic c);
    logic          acc, wa, wb, same;
    logic [DW-1:0] e;
    req_valid_a = ra.valid; we_a = ra.we; be_a = ra.be; addr_a = ra.addr; wdata_a = ra.wdata;
    req_valid_b = rb.valid; we_b = rb.we; be_b = rb.be; addr_b = rb.addr; wdata_b = rb.wdata;
    clr = c;
    acc  = (clr_left == 0);
    wa   = acc && ra.valid && ra.we;
    wb   = acc && rb.valid && rb.we;
    same = (ra.addr == rb.addr);
    if (acc && ra.valid && !ra.we) begin
      e = ref_mem[ra.addr];
      if (RDW_MODE == 1 && wb && same) e = ref_merge(e, rb.wdata, rb.be);
      qa.push_back('{e, cyc});
    end
    if (acc && rb.valid && !rb.we) begin
      e = ref_mem[rb.addr];
      if (RDW_MODE == 1 && wa && same) e = ref_merge(e, ra.wdata, ra.be);
      qb.push_back('{e, cyc});
    end
    if (wa && wb && same) begin
      ref_mem[ra.addr] = ref_merge(ref_merge(ref_mem[ra.addr], rb.wdata, rb.be), ra.wdata, ra.be);
    end else begin
      if (wa) ref_mem[ra.addr] = ref_merge(ref_mem[ra.addr], ra.wdata, ra.be);
      if (wb) ref_mem[rb.addr] = ref_merge(ref_mem[rb.addr], rb.wdata, rb.be);
    end
    @(posedge clk);
    exp_coll = wa && wb && same;
    if (c) begin
      clr_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    end else if (clr_left > 0) begin
      clr_left--;
    end
    @(negedge clk);
    drive_idle();
    chk_bit("init_done", init_done, clr_left == 0);
    chk_bit("req_ready_a", req_ready_a, clr_left == 0);
    chk_bit("req_ready_b", req_ready_b, clr_left == 0);
  endtask

  task automatic mon_port(input bit is_b);
    logic          v;
    logic [DW-1:0] d;
    exp_t          e;
    string         pn;
    int            qs;
    v  = is_b ? rvalid_b : rvalid_a;
    d  = is_b ? rdata_b : rdata_a;
    pn = is_b ? "b" : "a";
    qs = is_b ? qb.size() : qa.size();
    if (v) begin
      checks++;
      if (qs == 0) begin
        failures++;
        $display("FAIL rvalid_%s unexpected: rdata=%h required=no read outstanding", pn, d);
      end else begin
        if (is_b) e = qb.pop_front();
        else      e = qa.pop_front();
        if (d !== e.data || cyc != e.cyc + RD_LAT) begin
          failures++;
          $display("FAIL rdata_%s actual=%h at cycle %0d required=%h at cycle %0d",
                   pn, d, cyc, e.data, e.cyc + RD_LAT);
        end
      end
      if (is_b) last_b = d;
      else      last_a = d;
    end else begin
      chk(is_b ? "rdata_b_hold" : "rdata_a_hold", d, is_b ? last_b : last_a);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_a = '0;
        last_b = '0;
      end else begin
        mon_port(1'b0);
        mon_port(1'b1);
      end
      chk_bit("coll", coll, exp_coll);
    end
  end

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive_idle();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    repeat (3) @(negedge clk);
    chk_bit("rst_init_done", init_done, 1'b0);
    chk_bit("rst_ready_a", req_ready_a, 1'b0);
    chk_bit("rst_rvalid_b", rvalid_b, 1'b0);
    chk("rst_rdata_a", rdata_a, '0);
    chk_bit("rst_coll", coll, 1'b0);

    // release: ready stays low for DEPTH edges, then every word reads zero
    rst_n = 1'b1;
    clr_left = DEPTH;
    repeat (DEPTH) cycle(idle(), idle(), 1'b0);
    for (int a = 0; a < DEPTH; a++) cycle(rd(AW'(a)), rd(AW'(DEPTH - 1 - a)), 1'b0);

    // full write then cross-port read
    cycle(wr(3, 32'hDEADBEEF, 4'hF), idle(), 1'b0);
    cycle(idle(), rd(3), 1'b0);

    // partial write
    cycle(wr(5, 32'hAAAAAAAA, 4'hF), idle(), 1'b0);
    cycle(wr(5, 32'h11112222, 4'b0011), idle(), 1'b0);
    cycle(rd(5), rd(5), 1'b0);

    // same-address collision, then a different-address double write
    cycle(wr(7, 32'h11111111, 4'hC), wr(7, 32'h22222222, 4'hF), 1'b0);
    cycle(rd(7), wr(8, 32'h0BADF00D, 4'hF), 1'b0);
    cycle(wr(9, 32'h0, 4'hF), wr(10, 32'h12345678, 4'hF), 1'b0);

    // cross-port read during write, both directions, then wraparound addresses
    cycle(rd(9), wr(9, 32'h55, 4'h1), 1'b0);
    cycle(wr(10, 32'hCAFE0000, 4'hC), rd(10), 1'b0);
    cycle(rd(9), rd(10), 1'b0);
    cycle(wr(AW'(DEPTH - 1), 32'hF00DF00D, 4'hF), rd(0), 1'b0);
    cycle(rd(AW'(DEPTH - 1)), idle(), 1'b0);

    // randomized traffic with occasional clears
    for (int n = 0; n < 400; n++) cycle(rnd_req(), rnd_req(), $urandom_range(0, 149) == 0);
    while (clr_left > 0) cycle(rnd_req(), rnd_req(), 1'b0);

    // streamed reads with a clear on the last one, clear restarted mid-way
    for (int a = 0; a < 4; a++) cycle(rd(AW'(a)), idle(), a == 3);
    repeat (6) cycle(rnd_req(), rnd_req(), 1'b0);
    cycle(rnd_req(), rnd_req(), 1'b1);
    while (clr_left > 0) cycle(rnd_req(), rnd_req(), 1'b0);
    for (int a = 0; a < DEPTH; a++) cycle(rd(AW'(a)), rd(AW'(a + 5)), 1'b0);

    // reset asserted with reads just returned / in flight
    cycle(wr(2, 32'h13572468, 4'hF), idle(), 1'b0);
    cycle(rd(2), rd(2), 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk_bit("midrst_rvalid_a", rvalid_a, 1'b0);
    chk("midrst_rdata_b", rdata_b, '0);
    chk_bit("midrst_init_done", init_done, 1'b0);
    qa.delete();
    qb.delete();
    exp_coll = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    clr_left = DEPTH;
    while (clr_left > 0) cycle(idle(), idle(), 1'b0);
    cycle(rd(2), rd(3), 1'b0);

    repeat (RD_LAT + 2) cycle(idle(), idle(), 1'b0);
    chk("drain_qa", DW'(qa.size()), '0);
    chk("drain_qb", DW'(qb.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
